triangle_scan: RTL and testbench
================================

# triangle_scan

Bounding-box rasterizer that feeds the point-in-triangle checker. It accepts one triangle (three vertices) over a valid/ready handshake and computes its bounding box. It then walks every pixel of the box in raster order, issuing one point query per cycle to `in_triangle_wrap`, and re-associates the returned `is_inside` results with their coordinates. Inside pixels leave as a back-pressured fragment stream toward the frame-buffer writer.

## Interface
- `SYS_BIT_WIDTH`, 10, coordinate width W
- `H_RES`, 320, screen width in pixels
- `V_RES`, 240, screen height in pixels
- `DEPTH`, 8, in-flight credit limit; power of 2, at least 2

Ports:
- `clk_in` in 1: system clock
- `sys_rst_n` in 1: reset, synchronous, active-low; one clock domain only
- `tri_valid_in` in 1: triangle offered
- `tri_ready_out` out 1: high only in IDLE
- `tri_in` in 6W: packed as {ax,ay,bx,by,cx,cy}, ax in MSBs
- `tri_out` out 6W: latched vertices, wired to checker vertex inputs
- `point_valid_out` out 1: one-cycle query strobe to checker `valid_in`
- `point_x_out`, `point_y_out` out W each: query coordinate
- `check_valid_in` in 1: checker `valid_out`
- `check_inside_in` in 1: checker `is_inside`
- `frag_valid_out` out 1, `frag_ready_in` in 1: fragment handshake
- `frag_x_out`, `frag_y_out` out W each: inside pixel
- `busy_out` out 1: high in any state except IDLE
- `done_out` out 1: one-cycle pulse when the triangle is fully processed

## Operation
- States: IDLE → SETUP → SCAN → DRAIN → DONE → IDLE.
- IDLE:
  - `tri_ready_out`=1.
  - On `tri_valid_in`, latch `tri_in` into `tri_out` and go to SETUP.
- SETUP (1 cycle):
  - xmin/xmax/ymin/ymax are the unsigned W-bit min/max of the three vertices.
  - Box is clamped per Configuration.
  - If the box is empty (xmin>xmax or ymin>ymax), go to DRAIN. Otherwise set cursor to (xmin,ymin) and go to SCAN.
- SCAN:
  - Issue the cursor when `inflight + frag_count < DEPTH`.
  - After each issue, x increments. At xmax, x returns to xmin and y increments.
  - Issuing (xmax,ymax) goes to DRAIN.
- Coordinate FIFO (DEPTH entries): pushed on every issue, popped on every `check_valid_in`. `inflight` equals its occupancy.
- On a result: if `check_inside_in`=1, push the popped coordinate into the fragment FIFO (DEPTH entries); otherwise discard it. A result arriving with `inflight`=0 is ignored.
- Fragment FIFO drives `frag_*` first-word-fall-through. It pops on `frag_valid_out && frag_ready_in`.
- The credit rule guarantees neither FIFO overflows; the checker has no ready signal and is never stalled.
- DRAIN: wait for `inflight`=0 and fragment FIFO empty, then go to DONE.
- DONE: `done_out`=1 for one cycle, then IDLE.
- Simultaneous issue and result, or fragment push and pop in the same cycle: counts update by the net change.
- Reset, including mid-operation:
  - Returns to IDLE with both FIFOs emptied.
  - Every output goes to 0 except `tri_ready_out`=1.
  - Late checker results after reset see `inflight`=0 and are ignored.

## Timing
- Triangle handshake at edge N: SETUP in cycle N+1; first `point_valid_out` in cycle N+2 if credit is available.
- Peak throughput is one query per cycle. A box of P pixels needs at least P cycles in SCAN.
- Fragment order equals issue order, which is raster order. The fragment FIFO adds 1 cycle between `check_valid_in` and `frag_valid_out`.
- `done_out` asserts the cycle after DRAIN sees both FIFOs empty.
- An empty box gives `done_out` in cycle N+3 with no queries issued.
- The checker must return results in order, with any fixed latency; latency above DEPTH reduces throughput only.

## Configuration
- `TRIANGLE_SCAN_CLAMP_EN` defined:
  - xmax := min(xmax, H_RES-1) and ymax := min(ymax, V_RES-1).
  - The box is empty if xmin>H_RES-1 or ymin>V_RES-1.
- Not defined: the raw box is scanned across the full W-bit range; `H_RES`/`V_RES` are unused.

## Structure
- Package `scan_pkg`: state enum (IDLE, SETUP, SCAN, DRAIN, DONE), a bounding-box struct {xmin,xmax,ymin,ymax}, and a W-bit point struct {x,y}.
- One sub-module, `scan_fifo`: a parameterized sync FIFO with count output, instantiated twice (coordinate FIFO and fragment FIFO).

## Test plan
The checker model is an in-order delay line of latency 4.
- Triangle (0,0),(3,0),(0,3) with inside iff x+y≤3 and `frag_ready_in`=1 → 16 queries, (0,0)…(3,3) in raster order; 10 fragments in order; `done_out` exactly once.
- All vertices at (5,5) → exactly one query (5,5); one fragment if the model says inside; `done_out`.
- DEPTH=8, `frag_ready_in`=0, model always inside → exactly 8 queries then `point_valid_out` stays 0. Raising ready → remaining fragments drain in raster order, none lost or duplicated.
- Clamp on, (300,200),(400,200),(300,260) → box 300..319 × 200..239, 800 queries. Clamp off → 101×61 = 6161 queries.
- Clamp on, all vertices x≥320 → zero queries; `done_out` 3 cycles after the handshake.
- `sys_rst_n`=0 for 1 cycle mid-SCAN with results pending → all outputs reset, late results ignored; the next triangle gives the correct fragment count.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared types and helpers for the triangle_scan bounding-box rasterizer.
package scan_pkg;
  localparam int W = 10;
  typedef enum logic [2:0] {IDLE, SETUP, SCAN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [W-1:0] xmin, xmax, ymin, ymax;
  } bbox_t;
  typedef struct packed {
    logic [W-1:0] x, y;
  } point_t;
  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    return a < b ? (a < c ? a : c) : (b < c ? b : c);
  endfunction
  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/triangle_scan_if.sv
// triangle_scan_if: triangle input, checker query/result and fragment stream signals.
interface triangle_scan_if #(parameter int W = 10);
  logic tri_valid_in, tri_ready_out;
  logic [6*W-1:0] tri_in, tri_out;
  logic point_valid_out;
  logic [W-1:0] point_x_out, point_y_out;
  logic check_valid_in, check_inside_in;
  logic frag_valid_out, frag_ready_in;
  logic [W-1:0] frag_x_out, frag_y_out;
  logic busy_out, done_out;
  modport slave (
    input tri_valid_in, tri_in, check_valid_in, check_inside_in, frag_ready_in,
    output tri_ready_out, tri_out, point_valid_out, point_x_out, point_y_out,
    output frag_valid_out, frag_x_out, frag_y_out, busy_out, done_out
  );
  modport master (
    output tri_valid_in, tri_in, check_valid_in, check_inside_in, frag_ready_in,
    input tri_ready_out, tri_out, point_valid_out, point_x_out, point_y_out,
    input frag_valid_out, frag_x_out, frag_y_out, busy_out, done_out
  );
endinterface

// File: rtl/scan_fifo.sv
// scan_fifo: synchronous first-word-fall-through FIFO with occupancy count; DEPTH is a power of 2.
module scan_fifo #(
  parameter int DW = 20,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          sys_rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk_in) if (push) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/triangle_scan.sv
// triangle_scan: bounding-box rasterizer feeding a point-in-triangle checker.
// Define TRIANGLE_SCAN_CLAMP_EN to clip the box to the H_RES x V_RES screen.
module triangle_scan import scan_pkg::*; #(
  parameter int SYS_BIT_WIDTH = W,
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int DEPTH = 8
) (
  input logic clk_in,
  input logic sys_rst_n,
  triangle_scan_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = 6 * SYS_BIT_WIDTH;
`ifdef TRIANGLE_SCAN_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam logic [W-1:0] X_LAST = W'(H_RES - 1);
  localparam logic [W-1:0] Y_LAST = W'(V_RES - 1);
  state_t state, state_nx;
  logic [TW-1:0] tri_q;
  bbox_t raw, clip, box;
  point_t cur, cf_dout, ff_dout;
  logic [CW-1:0] cf_cnt, ff_cnt;
  logic issue, last, empty_box, cf_pop, ff_push, ff_pop, frag_valid;
  always_comb begin
    raw.xmin = min3(bus.tri_in[TW-1 -: W], bus.tri_in[4*W-1 -: W], bus.tri_in[2*W-1 -: W]);
    raw.xmax = max3(bus.tri_in[TW-1 -: W], bus.tri_in[4*W-1 -: W], bus.tri_in[2*W-1 -: W]);
    raw.ymin = min3(bus.tri_in[5*W-1 -: W], bus.tri_in[3*W-1 -: W], bus.tri_in[W-1 -: W]);
    raw.ymax = max3(bus.tri_in[5*W-1 -: W], bus.tri_in[3*W-1 -: W], bus.tri_in[W-1 -: W]);
    clip = raw;
    clip.xmax = (CLAMP && raw.xmax > X_LAST) ? X_LAST : raw.xmax;
    clip.ymax = (CLAMP && raw.ymax > Y_LAST) ? Y_LAST : raw.ymax;
  end
  // A clipped max below min also covers a box lying wholly off-screen.
  assign empty_box  = box.xmin > box.xmax || box.ymin > box.ymax;
  assign issue      = state == SCAN && cf_cnt + ff_cnt < CW'(DEPTH);
  assign last       = cur.x == box.xmax && cur.y == box.ymax;
  assign cf_pop     = bus.check_valid_in && cf_cnt != '0;
  assign ff_push    = cf_pop && bus.check_inside_in;
  assign frag_valid = ff_cnt != '0;
  assign ff_pop     = frag_valid && bus.frag_ready_in;
  always_ff @(posedge clk_in) state <= !sys_rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.tri_valid_in ? SETUP : IDLE;
      SETUP:   state_nx = empty_box ? DRAIN : SCAN;
      SCAN:    state_nx = issue && last ? DRAIN : SCAN;
      DRAIN:   state_nx = cf_cnt == '0 && ff_cnt == '0 ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) begin
      tri_q <= '0;
      box   <= '0;
      cur   <= '0;
    end else begin
      if (state == IDLE && bus.tri_valid_in) begin
        tri_q <= bus.tri_in;
        box   <= clip;
      end
      if (state == SETUP) begin
        cur.x <= box.xmin;
        cur.y <= box.ymin;
      end else if (issue) begin
        cur.x <= cur.x == box.xmax ? box.xmin : cur.x + 1'b1;
        cur.y <= cur.x == box.xmax ? cur.y + 1'b1 : cur.y;
      end
    end
  end
  always_comb begin
    bus.tri_ready_out   = state == IDLE;
    bus.busy_out        = state != IDLE;
    bus.done_out        = state == DONE;
    bus.tri_out         = tri_q;
    bus.point_valid_out = issue;
    bus.point_x_out     = issue ? cur.x : '0;
    bus.point_y_out     = issue ? cur.y : '0;
    bus.frag_valid_out  = frag_valid;
    bus.frag_x_out      = frag_valid ? ff_dout.x : '0;
    bus.frag_y_out      = frag_valid ? ff_dout.y : '0;
  end
  scan_fifo #(.DW(2 * W), .DEPTH(DEPTH)) u_coord (
    .clk_in(clk_in), .sys_rst_n(sys_rst_n), .push(issue), .pop(cf_pop),
    .din(cur), .dout(cf_dout), .count(cf_cnt)
  );
  scan_fifo #(.DW(2 * W), .DEPTH(DEPTH)) u_frag (
    .clk_in(clk_in), .sys_rst_n(sys_rst_n), .push(ff_push), .pop(ff_pop),
    .din(cf_dout), .dout(ff_dout), .count(ff_cnt)
  );
endmodule

// File: tb/tb_triangle_scan.sv
// tb_triangle_scan: table-driven and random triangles against a raster-order reference model.
module tb_triangle_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  triangle_scan_if #(.W(10)) bus ();
  triangle_scan dut (.clk_in(clk), .sys_rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [59:0] v;
    int mode;
    bit rnd;
    int exp_q;
    int exp_f;
  } vec_t;
  vec_t tab[6];
  int n_pass = 0, n_total = 0, done_cnt = 0, mode = 0;
  int q_seen[$], f_seen[$], exp_q[$], exp_f[$];
  logic [59:0] cur_v;
  logic [3:0] pv = '0, pin = '0;
  bit rnd_ready = 1'b0, ready_fix = 1'b1;
  function automatic bit inside_fn(input int m, input int x, input int y);
    return m == 0 ? (x + y <= 3) : m == 1 ? 1'b1 : ((x * 7 + y * 13) % 3 != 0);
  endfunction
  function automatic logic [59:0] pack(input int ax, ay, bx, by, cx, cy);
    return {10'(ax), 10'(ay), 10'(bx), 10'(by), 10'(cx), 10'(cy)};
  endfunction
  // Checker stand-in: in-order delay line of latency 4.
  always @(posedge clk) begin
    pv  <= {pv[2:0], bus.point_valid_out};
    pin <= {pin[2:0], inside_fn(mode, int'(bus.point_x_out), int'(bus.point_y_out))};
  end
  assign bus.check_valid_in  = pv[3];
  assign bus.check_inside_in = pin[3];
  always @(negedge clk) begin
    if (bus.point_valid_out) q_seen.push_back(int'(bus.point_x_out) * 1024 + int'(bus.point_y_out));
    if (bus.frag_valid_out && bus.frag_ready_in) f_seen.push_back(int'(bus.frag_x_out) * 1024 + int'(bus.frag_y_out));
    if (bus.done_out) done_cnt++;
  end
  initial begin
    bus.frag_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.frag_ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end
  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic build_model(input logic [59:0] v, input int m);
    int xs[3], ys[3];
    int xmin, xmax, ymin, ymax;
    for (int i = 0; i < 3; i++) begin
      xs[i] = int'(v[59 - 20 * i -: 10]);
      ys[i] = int'(v[49 - 20 * i -: 10]);
    end
    xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < xmin) xmin = xs[i];
      if (xs[i] > xmax) xmax = xs[i];
      if (ys[i] < ymin) ymin = ys[i];
      if (ys[i] > ymax) ymax = ys[i];
    end
`ifdef TRIANGLE_SCAN_CLAMP_EN
    if (xmax > 319) xmax = 319;
    if (ymax > 239) ymax = 239;
`endif
    exp_q.delete();
    exp_f.delete();
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++) begin
        exp_q.push_back(x * 1024 + y);
        if (inside_fn(m, x, y)) exp_f.push_back(x * 1024 + y);
      end
  endtask
  function automatic int diff_q();
    int n = 0;
    for (int i = 0; i < q_seen.size() && i < exp_q.size(); i++) if (q_seen[i] != exp_q[i]) n++;
    return n;
  endfunction
  function automatic int diff_f();
    int n = 0;
    for (int i = 0; i < f_seen.size() && i < exp_f.size(); i++) if (f_seen[i] != exp_f[i]) n++;
    return n;
  endfunction
  task automatic start_tri(input logic [59:0] v, input int m);
    int t = 0;
    build_model(v, m);
    q_seen.delete();
    f_seen.delete();
    done_cnt = 0;
    mode = m;
    cur_v = v;
    while (!bus.tri_ready_out && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    bus.tri_in = v;
    bus.tri_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.tri_valid_in = 1'b0;
  endtask
  task automatic finish_tri(input string tag, input int tq, input int tf);
    int t = 0;
    while (done_cnt == 0 && t < 40000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_query_count"}, q_seen.size(), exp_q.size());
    check({tag, "_query_order"}, diff_q(), 0);
    check({tag, "_frag_count"}, f_seen.size(), exp_f.size());
    check({tag, "_frag_order"}, diff_f(), 0);
    check({tag, "_tri_out"}, bus.tri_out, cur_v);
    check({tag, "_idle_busy"}, bus.busy_out, 0);
    if (tq >= 0) check({tag, "_table_queries"}, q_seen.size(), tq);
    if (tf >= 0) check({tag, "_table_frags"}, f_seen.size(), tf);
  endtask
  initial begin
    bus.tri_valid_in = 1'b0;
    bus.tri_in = '0;
    tab[0] = '{pack(0, 0, 3, 0, 0, 3), 0, 1'b0, 16, 10};
    tab[1] = '{pack(5, 5, 5, 5, 5, 5), 1, 1'b0, 1, 1};
`ifdef TRIANGLE_SCAN_CLAMP_EN
    tab[2] = '{pack(300, 200, 400, 200, 300, 260), 2, 1'b1, 800, -1};
    tab[3] = '{pack(330, 10, 340, 10, 335, 20), 1, 1'b0, 0, 0};
    tab[4] = '{pack(1020, 1020, 1023, 1023, 1021, 1023), 1, 1'b1, 0, 0};
`else
    tab[2] = '{pack(300, 200, 400, 200, 300, 260), 2, 1'b1, 6161, -1};
    tab[3] = '{pack(330, 10, 340, 10, 335, 20), 1, 1'b0, 121, 121};
    tab[4] = '{pack(1020, 1020, 1023, 1023, 1021, 1023), 1, 1'b1, 16, 16};
`endif
    tab[5] = '{pack(7, 9, 2, 4, 9, 1), 2, 1'b1, 72, -1};
    repeat (3) @(posedge clk);
    #1;
    check("reset_tri_ready", bus.tri_ready_out, 1);
    check("reset_busy", bus.busy_out, 0);
    check("reset_point_valid", bus.point_valid_out, 0);
    check("reset_frag_valid", bus.frag_valid_out, 0);
    check("reset_done", bus.done_out, 0);
    check("reset_tri_out", bus.tri_out, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rnd_ready = tab[i].rnd;
      start_tri(tab[i].v, tab[i].mode);
      check($sformatf("vec%0d_busy_setup", i), bus.busy_out, 1);
      finish_tri($sformatf("vec%0d", i), tab[i].exp_q, tab[i].exp_f);
    end
`ifdef TRIANGLE_SCAN_CLAMP_EN
    rnd_ready = 1'b0;
    start_tri(tab[3].v, 1);
    @(posedge clk);
    #1;
    check("empty_done_early", bus.done_out, 0);
    @(posedge clk);
    #1;
    check("empty_done_n3", bus.done_out, 1);
    finish_tri("empty_timing", 0, 0);
`endif
    rnd_ready = 1'b0;
    ready_fix = 1'b0;
    start_tri(pack(0, 0, 3, 0, 0, 3), 1);
    @(posedge clk);
    #1;
    check("bp_first_query_valid", bus.point_valid_out, 1);
    check("bp_first_query_xy", int'(bus.point_x_out) * 1024 + int'(bus.point_y_out), 0);
    repeat (30) @(posedge clk);
    #1;
    check("bp_stalled_queries", q_seen.size(), 8);
    check("bp_stalled_point_valid", bus.point_valid_out, 0);
    check("bp_head_valid", bus.frag_valid_out, 1);
    check("bp_head_xy", int'(bus.frag_x_out) * 1024 + int'(bus.frag_y_out), 0);
    ready_fix = 1'b1;
    finish_tri("bp", 16, 16);
    rnd_ready = 1'b1;
    start_tri(tab[2].v, 1);
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid_scan_busy", bus.busy_out, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_tri_ready", bus.tri_ready_out, 1);
    check("rst_busy", bus.busy_out, 0);
    check("rst_point_valid", bus.point_valid_out, 0);
    check("rst_frag_valid", bus.frag_valid_out, 0);
    check("rst_frag_xy", int'(bus.frag_x_out) * 1024 + int'(bus.frag_y_out), 0);
    check("rst_tri_out", bus.tri_out, 0);
    check("rst_done", bus.done_out, 0);
    rst_n = 1'b1;
    q_seen.delete();
    f_seen.delete();
    done_cnt = 0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_late_results_frags", f_seen.size(), 0);
    check("rst_no_queries", q_seen.size(), 0);
    check("rst_no_done", done_cnt, 0);
    start_tri(tab[5].v, tab[5].mode);
    finish_tri("after_rst", tab[5].exp_q, tab[5].exp_f);
    for (int i = 0; i < 4; i++) begin
      int bx, by;
      bx = int'($urandom_range(0, 300));
      by = int'($urandom_range(0, 220));
      start_tri(pack(bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                     bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                     bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12))), 2);
      finish_tri($sformatf("rand%0d", i), -1, -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
